// File: rtl/ifetch_pkg.sv
// Shared types and address-split helpers for the instruction fetch cache.
package ifetch_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REFILL,
        WRITE
    } state_t;

    localparam int unsigned OFFSET_W = 4;
    localparam int unsigned BEATS    = 128 / 32;

    function automatic int unsigned idx_width(input int unsigned num_lines);
        return $clog2(num_lines);
    endfunction

    function automatic int unsigned tag_width(input int unsigned data_w,
                                              input int unsigned num_lines);
        return data_w - OFFSET_W - idx_width(num_lines);
    endfunction

endpackage

// File: rtl/icache_line_array.sv
// Direct-mapped line storage: valid/tag/data flops, combinational read, one write port.
module icache_line_array
    import ifetch_pkg::*;
#(
    parameter int unsigned DATA_WIDTH       = 32,
    parameter int unsigned CACHE_LINE_WIDTH = 128,
    parameter int unsigned NUM_LINES        = 16,
    localparam int unsigned IDX_W           = idx_width(NUM_LINES),
    localparam int unsigned TAG_W           = tag_width(DATA_WIDTH, NUM_LINES)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [IDX_W-1:0]            rd_idx,
    output logic                        rd_valid,
    output logic [TAG_W-1:0]            rd_tag,
    output logic [CACHE_LINE_WIDTH-1:0] rd_line,
    input  logic                        we,
    input  logic [IDX_W-1:0]            wr_idx,
    input  logic [TAG_W-1:0]            wr_tag,
    input  logic [CACHE_LINE_WIDTH-1:0] wr_line
);

    logic [NUM_LINES-1:0]        valid_q;
    logic [TAG_W-1:0]            tag_q  [NUM_LINES];
    logic [CACHE_LINE_WIDTH-1:0] data_q [NUM_LINES];

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else if (we) begin
            valid_q[wr_idx] <= 1'b1;
        end
    end

    // Tag and data need no reset: they are only trusted behind a set valid bit.
    always_ff @(posedge clk) begin
        if (we) begin
            tag_q[wr_idx]  <= wr_tag;
            data_q[wr_idx] <= wr_line;
        end
    end

    always_comb begin
        rd_valid = valid_q[rd_idx];
        rd_tag   = tag_q[rd_idx];
        rd_line  = data_q[rd_idx];
    end

endmodule

// File: rtl/icache_fetch.sv
// Direct-mapped read-only instruction cache with a multi-beat refill FSM.
module icache_fetch
    import ifetch_pkg::*;
#(
    parameter int unsigned DATA_WIDTH       = 32,
    parameter int unsigned CACHE_LINE_WIDTH = 128,
    parameter int unsigned NUM_LINES        = 16,
    parameter int unsigned MEM_WIDTH        = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [DATA_WIDTH-1:0]       PC_in,
    input  logic                        rd_en,
    input  logic                        flush,
    output logic [CACHE_LINE_WIDTH-1:0] D_out,
    output logic                        d_out_valid,
    output logic                        icache_stall,
    output logic                        mem_req,
    output logic [DATA_WIDTH-1:0]       mem_addr,
    input  logic                        mem_rvalid,
    input  logic [MEM_WIDTH-1:0]        mem_rdata
);

    localparam int unsigned IDX_W  = idx_width(NUM_LINES);
    localparam int unsigned TAG_W  = tag_width(DATA_WIDTH, NUM_LINES);
    localparam int unsigned NBEATS = CACHE_LINE_WIDTH / MEM_WIDTH;
    localparam int unsigned CNT_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam logic [DATA_WIDTH-1:0] LINE_MASK = ~DATA_WIDTH'(2 ** OFFSET_W - 1);
    localparam logic [CNT_W-1:0]      LAST_BEAT = CNT_W'(NBEATS - 1);

    state_t state, state_next;

    logic [CNT_W-1:0]            beat_cnt;
    logic [MEM_WIDTH-1:0]        refill_buf [NBEATS];
    logic [CACHE_LINE_WIDTH-1:0] fill_line;

    logic [IDX_W-1:0]            pc_idx;
    logic [TAG_W-1:0]            pc_tag;
    logic [IDX_W-1:0]            fill_idx;
    logic [TAG_W-1:0]            fill_tag;

    logic                        arr_valid;
    logic [TAG_W-1:0]            arr_tag;
    logic [CACHE_LINE_WIDTH-1:0] arr_line;
    logic                        arr_we;
    logic                        hit;
    logic                        capture;
    logic                        beat_fire;

    assign pc_idx    = PC_in[OFFSET_W +: IDX_W];
    assign pc_tag    = PC_in[DATA_WIDTH-1 -: TAG_W];
    assign fill_idx  = mem_addr[OFFSET_W +: IDX_W];
    assign fill_tag  = mem_addr[DATA_WIDTH-1 -: TAG_W];
    assign hit       = arr_valid && (arr_tag == pc_tag);
    assign beat_fire = (state == REFILL) && mem_rvalid;
    assign mem_req   = (state == REFILL);

    icache_line_array #(
        .DATA_WIDTH       (DATA_WIDTH),
        .CACHE_LINE_WIDTH (CACHE_LINE_WIDTH),
        .NUM_LINES        (NUM_LINES)
    ) u_array (
        .clk      (clk),
        .rst      (rst),
        .rd_idx   (pc_idx),
        .rd_valid (arr_valid),
        .rd_tag   (arr_tag),
        .rd_line  (arr_line),
        .we       (arr_we),
        .wr_idx   (fill_idx),
        .wr_tag   (fill_tag),
        .wr_line  (fill_line)
    );

    always_comb begin
        fill_line = '0;
        for (int unsigned i = 0; i < NBEATS; i++) begin
            fill_line[i*MEM_WIDTH +: MEM_WIDTH] = refill_buf[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            beat_cnt <= '0;
            mem_addr <= '0;
        end else begin
            state <= state_next;
            if (capture) begin
                mem_addr <= PC_in & LINE_MASK;
                beat_cnt <= '0;
            end else if (beat_fire) begin
                beat_cnt <= beat_cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && beat_fire) begin
            refill_buf[beat_cnt] <= mem_rdata;
        end
    end

    // A flush never aborts REFILL/WRITE: the fetched line is still valid memory
    // data, and the redirected PC is looked up fresh once back in IDLE.
    always_comb begin
        state_next   = state;
        d_out_valid  = 1'b0;
        D_out        = '0;
        icache_stall = 1'b0;
        capture      = 1'b0;
        arr_we       = 1'b0;
        case (state)
            IDLE: begin
                if (rd_en && !flush) begin
                    if (hit) begin
                        d_out_valid = 1'b1;
                        D_out       = arr_line;
                    end else begin
                        icache_stall = 1'b1;
                        capture      = 1'b1;
                        state_next   = REFILL;
                    end
                end
            end
            REFILL: begin
                icache_stall = 1'b1;
                if (mem_rvalid && beat_cnt == LAST_BEAT) begin
                    state_next = WRITE;
                end
            end
            WRITE: begin
                icache_stall = 1'b1;
                arr_we       = 1'b1;
                state_next   = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_icache_fetch.sv
// Directed self-checking bench for icache_fetch.
`timescale 1ns/1ps
module tb_icache_fetch;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  PC_in;
    logic         rd_en;
    logic         flush;
    logic [127:0] D_out;
    logic         d_out_valid;
    logic         icache_stall;
    logic         mem_req;
    logic [31:0]  mem_addr;
    logic         mem_rvalid;
    logic [31:0]  mem_rdata;

    int checks = 0;
    int errors = 0;

    localparam logic [127:0] LINE100 = {32'h0000000D, 32'h0000000C, 32'h0000000B, 32'h0000000A};
    localparam logic [127:0] LINE200 = {32'h22220003, 32'h22220002, 32'h22220001, 32'h22220000};
    localparam logic [127:0] LINE300 = {32'h33330003, 32'h33330002, 32'h33330001, 32'h33330000};
    localparam logic [127:0] LINE040 = {32'h04040003, 32'h04040002, 32'h04040001, 32'h04040000};
    localparam logic [127:0] LINE500 = {32'hCAFE0003, 32'hBEEF0002, 32'hDEAD0001, 32'hF00D0000};

    always #5 clk = ~clk;

    icache_fetch #(
        .DATA_WIDTH       (32),
        .CACHE_LINE_WIDTH (128),
        .NUM_LINES        (16),
        .MEM_WIDTH        (32)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .PC_in        (PC_in),
        .rd_en        (rd_en),
        .flush        (flush),
        .D_out        (D_out),
        .d_out_valid  (d_out_valid),
        .icache_stall (icache_stall),
        .mem_req      (mem_req),
        .mem_addr     (mem_addr),
        .mem_rvalid   (mem_rvalid),
        .mem_rdata    (mem_rdata)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives one line's beats (optionally separated by idle cycles) and then the WRITE cycle.
    task automatic drive_refill(input logic [127:0] line, input int gap);
        for (int b = 0; b < 4; b++) begin
            mem_rvalid = 1'b1;
            mem_rdata  = line[b*32 +: 32];
            step();
            mem_rvalid = 1'b0;
            mem_rdata  = 32'hxxxx_xxxx;
            if (b < 3) begin
                for (int g = 0; g < gap; g++) step();
            end
        end
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1; rd_en = 1'b0; flush = 1'b0; PC_in = 32'h0;
        mem_rvalid = 1'b0; mem_rdata = 32'h0;
        step(); step();
        rst = 1'b0;
        #1;
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req got %b exp 0", mem_req); end
        checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL reset_mem_addr got %h exp 0", mem_addr); end
        checks++; if (d_out_valid !== 1'b0) begin errors++; $display("FAIL reset_dvalid got %b exp 0", d_out_valid); end
        checks++; if (icache_stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b exp 0", icache_stall); end
        checks++; if (D_out !== 128'h0) begin errors++; $display("FAIL reset_dout got %h exp 0", D_out); end
        step();
    endtask

    task automatic test_cold_miss();
        PC_in = 32'h100; rd_en = 1'b1;
        #1;
        checks++; if (icache_stall !== 1'b1) begin errors++; $display("FAIL cold_detect_stall got %b exp 1", icache_stall); end
        checks++; if (d_out_valid !== 1'b0) begin errors++; $display("FAIL cold_detect_dvalid got %b exp 0", d_out_valid); end
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL cold_detect_req got %b exp 0", mem_req); end
        step();
        checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL cold_req got %b exp 1", mem_req); end
        checks++; if (mem_addr !== 32'h100) begin errors++; $display("FAIL cold_addr got %h exp 00000100", mem_addr); end
        drive_refill(LINE100, 0);
        checks++; if (d_out_valid !== 1'b1) begin errors++; $display("FAIL cold_hit_valid got %b exp 1", d_out_valid); end
        checks++; if (D_out !== LINE100) begin errors++; $display("FAIL cold_hit_data got %h exp %h", D_out, LINE100); end
        checks++; if (icache_stall !== 1'b0) begin errors++; $display("FAIL cold_hit_stall got %b exp 0", icache_stall); end
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL cold_hit_req got %b exp 0", mem_req); end
    endtask

    task automatic test_hit();
        PC_in = 32'h108; rd_en = 1'b1;
        #1;
        checks++; if (d_out_valid !== 1'b1) begin errors++; $display("FAIL hit108_valid got %b exp 1", d_out_valid); end
        checks++; if (D_out !== LINE100) begin errors++; $display("FAIL hit108_data got %h exp %h", D_out, LINE100); end
        step();
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL hit108_req got %b exp 0", mem_req); end
        PC_in = 32'h10C; flush = 1'b1;
        #1;
        checks++; if (d_out_valid !== 1'b0) begin errors++; $display("FAIL hit_flush_valid got %b exp 0", d_out_valid); end
        checks++; if (D_out !== 128'h0) begin errors++; $display("FAIL hit_flush_data got %h exp 0", D_out); end
        step();
        flush = 1'b0;
        #1;
        checks++; if (D_out !== LINE100) begin errors++; $display("FAIL hit10c_data got %h exp %h", D_out, LINE100); end
        step();
    endtask

    task automatic test_conflict();
        PC_in = 32'h200; rd_en = 1'b1;
        #1;
        checks++; if (d_out_valid !== 1'b0 || icache_stall !== 1'b1) begin errors++; $display("FAIL conf200_miss got valid=%b stall=%b exp valid=0 stall=1", d_out_valid, icache_stall); end
        step();
        checks++; if (mem_addr !== 32'h200) begin errors++; $display("FAIL conf200_addr got %h exp 00000200", mem_addr); end
        drive_refill(LINE200, 0);
        checks++; if (D_out !== LINE200 || d_out_valid !== 1'b1) begin errors++; $display("FAIL conf200_hit got %h/%b exp %h/1", D_out, d_out_valid, LINE200); end
        step();
        PC_in = 32'h100;
        #1;
        checks++; if (d_out_valid !== 1'b0 || icache_stall !== 1'b1) begin errors++; $display("FAIL conf100_remiss got valid=%b stall=%b exp valid=0 stall=1", d_out_valid, icache_stall); end
        step();
        checks++; if (mem_addr !== 32'h100) begin errors++; $display("FAIL conf100_addr got %h exp 00000100", mem_addr); end
        drive_refill(LINE100, 0);
        checks++; if (D_out !== LINE100) begin errors++; $display("FAIL conf100_hit got %h exp %h", D_out, LINE100); end
        step();
    endtask

    task automatic test_flush_refill();
        PC_in = 32'h300; rd_en = 1'b1;
        step();
        checks++; if (mem_addr !== 32'h300) begin errors++; $display("FAIL fl300_addr got %h exp 00000300", mem_addr); end
        for (int b = 0; b < 4; b++) begin
            mem_rvalid = 1'b1;
            mem_rdata  = LINE300[b*32 +: 32];
            if (b == 2) begin flush = 1'b1; PC_in = 32'h40; end
            #1;
            checks++; if (d_out_valid !== 1'b0) begin errors++; $display("FAIL fl_beat%0d_valid got %b exp 0", b, d_out_valid); end
            step();
            flush = 1'b0;
        end
        mem_rvalid = 1'b0;
        #1;
        checks++; if (d_out_valid !== 1'b0 || icache_stall !== 1'b1) begin errors++; $display("FAIL fl_write got valid=%b stall=%b exp valid=0 stall=1", d_out_valid, icache_stall); end
        step();
        checks++; if (d_out_valid !== 1'b0 || icache_stall !== 1'b1) begin errors++; $display("FAIL fl040_miss got valid=%b stall=%b exp valid=0 stall=1", d_out_valid, icache_stall); end
        step();
        checks++; if (mem_addr !== 32'h40) begin errors++; $display("FAIL fl040_addr got %h exp 00000040", mem_addr); end
        drive_refill(LINE040, 0);
        checks++; if (D_out !== LINE040 || d_out_valid !== 1'b1) begin errors++; $display("FAIL fl040_hit got %h/%b exp %h/1", D_out, d_out_valid, LINE040); end
        step();
        PC_in = 32'h304;
        #1;
        checks++; if (D_out !== LINE300 || d_out_valid !== 1'b1) begin errors++; $display("FAIL fl300_hit got %h/%b exp %h/1", D_out, d_out_valid, LINE300); end
        step();
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL fl300_req got %b exp 0", mem_req); end
    endtask

    task automatic test_stalled_beats();
        PC_in = 32'h500; rd_en = 1'b1;
        step();
        for (int b = 0; b < 4; b++) begin
            mem_rvalid = 1'b1;
            mem_rdata  = LINE500[b*32 +: 32];
            step();
            mem_rvalid = 1'b0;
            mem_rdata  = 32'hFFFF_FFFF;
            if (b < 3) begin
                for (int g = 0; g < 3; g++) begin
                    #1;
                    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h500) begin errors++; $display("FAIL gap_b%0d_g%0d got req=%b addr=%h exp req=1 addr=00000500", b, g, mem_req, mem_addr); end
                    step();
                end
            end
        end
        step();
        checks++; if (D_out !== LINE500 || d_out_valid !== 1'b1) begin errors++; $display("FAIL gap_line got %h/%b exp %h/1", D_out, d_out_valid, LINE500); end
        step();
    endtask

    task automatic test_no_rd_en();
        PC_in = 32'h700; rd_en = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
        #1;
        checks++; if (d_out_valid !== 1'b0 || icache_stall !== 1'b0 || D_out !== 128'h0) begin errors++; $display("FAIL nord_idle got valid=%b stall=%b dout=%h exp 0/0/0", d_out_valid, icache_stall, D_out); end
        step(); step();
        mem_rvalid = 1'b0;
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL nord_req got %b exp 0", mem_req); end
        rd_en = 1'b1; flush = 1'b1;
        #1;
        checks++; if (icache_stall !== 1'b0) begin errors++; $display("FAIL flushmiss_stall got %b exp 0", icache_stall); end
        step();
        rd_en = 1'b0; flush = 1'b0;
        #1;
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL flushmiss_req got %b exp 0", mem_req); end
        step();
    endtask

    task automatic test_reset_refill();
        PC_in = 32'h900; rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL rr_req got %b exp 1", mem_req); end
        mem_rvalid = 1'b1; mem_rdata = 32'h9;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        checks++; if (mem_req !== 1'b0 || mem_addr !== 32'h0) begin errors++; $display("FAIL rr_out got req=%b addr=%h exp req=0 addr=0", mem_req, mem_addr); end
        checks++; if (icache_stall !== 1'b0 || d_out_valid !== 1'b0 || D_out !== 128'h0) begin errors++; $display("FAIL rr_idle got stall=%b valid=%b dout=%h exp 0/0/0", icache_stall, d_out_valid, D_out); end
        for (int i = 0; i < 3; i++) step();
        mem_rvalid = 1'b0;
        checks++; if (mem_req !== 1'b0 || icache_stall !== 1'b0) begin errors++; $display("FAIL rr_late got req=%b stall=%b exp 0/0", mem_req, icache_stall); end
        PC_in = 32'h108; rd_en = 1'b1;
        #1;
        checks++; if (d_out_valid !== 1'b0 || icache_stall !== 1'b1) begin errors++; $display("FAIL rr_invalidated got valid=%b stall=%b exp valid=0 stall=1", d_out_valid, icache_stall); end
        rd_en = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_cold_miss();
        test_hit();
        test_conflict();
        test_flush_refill();
        test_stalled_beats();
        test_no_rd_en();
        test_reset_refill();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got running exp finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/icache_fetch.md
# icache_fetch

Direct-mapped, read-only instruction cache that sits directly upstream of the instruction fetch queue. Each cycle it looks up the fetch PC and returns a full 128-bit line (four 32-bit instructions) with a valid flag. On a miss it stalls fetch, refills the line from instruction memory in 32-bit beats and then resumes. Branch/jump redirects discard any in-flight result without corrupting the array.

## Interface
Parameters:
- DATA_WIDTH, 32, address and instruction width
- CACHE_LINE_WIDTH, 128, line width; fixed at 4 instructions
- NUM_LINES, 16, number of lines; power of two, ≥2
- MEM_WIDTH, 32, refill beat width; CACHE_LINE_WIDTH/MEM_WIDTH beats per line (4)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- PC_in  in  DATA_WIDTH  fetch address from IFQ
- rd_en  in  1  IFQ can accept a line (IFQ rd_en_o)
- flush  in  1  redirect (jmp_branch_valid); drop the current result
- D_out  out  CACHE_LINE_WIDTH  line data; instruction k at bits [32k+31:32k]
- d_out_valid  out  1  D_out holds the line for PC_in this cycle
- icache_stall  out  1  miss in progress; IFQ must hold PC_in
- mem_req  out  1  refill request, held until last beat
- mem_addr  out  DATA_WIDTH  line-aligned refill address (bits [3:0]=0)
- mem_rvalid  in  1  beat valid
- mem_rdata  in  MEM_WIDTH  beat data, lowest word first

## Operation
- Address split: offset = PC_in[3:0] (ignored for lookup), index = PC_in[4+IDX-1:4], IDX=log2(NUM_LINES), tag = PC_in[DATA_WIDTH-1:4+IDX].
- Storage: valid bit, tag, data per line; all in flops; combinational read.
- FSM states: IDLE, REFILL, WRITE.
- IDLE: hit = valid[index] && tag match && rd_en && !flush. On hit: D_out = line, d_out_valid=1. On miss with rd_en && !flush: latch mem_addr = {PC_in[31:4],4'b0}, go REFILL. With rd_en=0 or flush=1: no lookup result, no state change.
- REFILL: mem_req=1, mem_addr stable. Each mem_rvalid writes mem_rdata into refill buffer slot beat_cnt and increments the 2-bit beat_cnt. On the last beat, go WRITE.
- WRITE: write the buffer into data[index], set tag and valid, go IDLE. The next IDLE cycle re-looks up and hits if PC_in is unchanged.
- icache_stall=1 in REFILL and WRITE, and in the IDLE cycle that detects a miss.
- A flush during REFILL/WRITE does not abort the refill. The line completes and is installed (it is valid memory data), but no d_out_valid is produced for it. The next lookup uses the redirected PC_in.
- D_out is 0 whenever d_out_valid=0.

## Timing
- Reset (any state): all valid bits 0, state IDLE, beat_cnt 0, mem_req 0, mem_addr 0, d_out_valid 0, icache_stall 0, D_out 0. Tag/data contents are don't-care.
- Hit latency: 0 cycles (same-cycle combinational).
- Miss penalty: 1 (detect) + N beat cycles + 1 (WRITE); the hit follows in the next cycle. Minimum 6 cycles with back-to-back mem_rvalid.
- mem_rvalid is ignored outside REFILL. Gaps between beats are allowed.
- Reset during REFILL: mem_req drops the next cycle. Beats still returned by memory are ignored.
- Same index, different tag: a refill overwrites the line (no replacement choice).
- Flush and miss in the same IDLE cycle: no refill starts.

## Structure
- Package ifetch_pkg: state enum (IDLE, REFILL, WRITE), OFFSET_W=4, BEATS=CACHE_LINE_WIDTH/MEM_WIDTH, and index/tag width functions.
- Sub-module icache_line_array: valid/tag/data storage with a combinational read port and a single write port (index, tag, line, we). The FSM, refill buffer and beat counter stay in icache_fetch.

## Test plan
- Cold miss: reset, PC_in=0x100, rd_en=1 -> mem_req=1 with mem_addr=0x100; beats 0xA,0xB,0xC,0xD -> 2 cycles after the last beat, d_out_valid=1 and D_out=0x0000000D_0000000C_0000000B_0000000A.
- Hit after fill: PC_in=0x108 -> same-cycle d_out_valid=1, same line, mem_req stays 0.
- Conflict: fill 0x100, then PC_in=0x200 (same index, NUM_LINES=16) -> miss, refill with mem_addr=0x200; a subsequent access to 0x100 misses again.
- Flush mid-refill: miss at 0x300, assert flush on beat 2, PC_in moves to 0x40 -> the 0x300 line is installed without d_out_valid; 0x40 then misses and refills; a later access to 0x300 hits.
- Stalled beats: insert 3 idle cycles between beats -> mem_addr stays stable, beat_cnt does not advance, final line is correct.
- rd_en=0 with a miss address -> no mem_req, d_out_valid=0. Reset asserted during REFILL -> all outputs reach their reset values the next cycle, and late mem_rvalid does not change state.
